// File: rtl/PARAMS_BN254_d0.sv
// Shared types and constants for the BN254 multiplier datapath.
// A redundant_poly_L3 value is a vector of independent limbs; each limb
// carries guard bits so several additions can be stacked before the
// downstream reducer resolves carries.
package PARAMS_BN254_d0;

    localparam int NLIMB  = 8;
    localparam int LIMB_W = 36;

    typedef logic [NLIMB-1:0][LIMB_W-1:0] redundant_poly_L3;

    // Frame types seen on the postadder mode input (2'b11 behaves as pass).
    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_FP2     = 2'b01;
    localparam logic [1:0] MODE_SUMDIFF = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_T1 = 2'd1,
        WAIT_T2 = 2'd2
    } postadd_state_t;

endpackage

// File: rtl/poly_adder_L3_L3.sv
// Redundant L3 adder/subtractor: limb-wise add or subtract with no carry
// propagation between limbs. Each limb wraps modulo 2^LIMB_W on its own.
module poly_adder_L3_L3
    import PARAMS_BN254_d0::*;
#(
    parameter bit SUB = 1'b0
) (
    input  redundant_poly_L3 a,
    input  redundant_poly_L3 b,
    output redundant_poly_L3 y
);

    // Independent per-limb add (SUB=0) or subtract (SUB=1).
    always_comb begin
        y = '0;
        for (int i = 0; i < NLIMB; i++) begin
            if (SUB) y[i] = a[i] - b[i];
            else     y[i] = a[i] + b[i];
        end
    end

endmodule

// File: rtl/postadder.sv
// Karatsuba post-adder for BN254 Fp2 products.
// Recombines a frame of Montgomery-reduced products into Z0/Z1:
//   pass    : Z0 = T0,          Z1 = 0
//   sum/diff: Z0 = T0 - T1,     Z1 = T0 + T1
//   Fp2     : Z0 = T0 - T1,     Z1 = T2 - (T0 + T1)
// With T0 = a0b0, T1 = a1b1, T2 = (a0+a1)(b0+b1) the Fp2 frame yields
// c0 = a0b0 - a1b1 and c1 = a0b1 + a1b0 (u^2 = -1). No reduction here.
//
// Handshake: valid-only, no ready. Every cycle with in_valid=1 consumes P
// as the next frame element; out_valid is a one-cycle pulse that the
// consumer must take, and Z0/Z1 hold their value between pulses.
//
// Build option POSTADDER_OUTREG_EN: extra register stage on Z0/Z1/out_valid
// (latency 2 instead of 1, same throughput).
module postadder
    import PARAMS_BN254_d0::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  redundant_poly_L3 P,
    output logic             out_valid,
    output redundant_poly_L3 Z0,
    output redundant_poly_L3 Z1,
    output logic             busy
);

    postadd_state_t   state, state_nx;
    logic [1:0]       mode_r;
    redundant_poly_L3 t0_r, s_r, d_r;
    redundant_poly_L3 sum_w, diff_w, psub_w;

    logic             ld_t0, ld_sd, ov_nx;
    redundant_poly_L3 z0_nx, z1_nx;
    logic             ov_r;
    redundant_poly_L3 z0_r, z1_r;

    poly_adder_L3_L3 #(.SUB(1'b0)) u_sum  (.a(t0_r), .b(P),   .y(sum_w));
    poly_adder_L3_L3 #(.SUB(1'b1)) u_diff (.a(t0_r), .b(P),   .y(diff_w));
    poly_adder_L3_L3 #(.SUB(1'b1)) u_psub (.a(P),    .b(s_r), .y(psub_w));

    // Next-state and datapath control; idle cycles (in_valid=0) change nothing.
    always_comb begin
        state_nx = state;
        ld_t0    = 1'b0;
        ld_sd    = 1'b0;
        ov_nx    = 1'b0;
        z0_nx    = z0_r;
        z1_nx    = z1_r;
        if (in_valid) begin
            unique case (state)
                IDLE: begin
                    if (mode == MODE_FP2 || mode == MODE_SUMDIFF) begin
                        ld_t0    = 1'b1;
                        state_nx = WAIT_T1;
                    end else begin
                        ov_nx = 1'b1;
                        z0_nx = P;
                        z1_nx = '0;
                    end
                end
                WAIT_T1: begin
                    ld_sd = 1'b1;
                    if (mode_r == MODE_SUMDIFF) begin
                        ov_nx    = 1'b1;
                        z0_nx    = diff_w;
                        z1_nx    = sum_w;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_T2;
                    end
                end
                WAIT_T2: begin
                    ov_nx    = 1'b1;
                    z0_nx    = d_r;
                    z1_nx    = psub_w;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, partial-product buffers and first output stage.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            mode_r <= '0;
            t0_r   <= '0;
            s_r    <= '0;
            d_r    <= '0;
            ov_r   <= 1'b0;
            z0_r   <= '0;
            z1_r   <= '0;
        end else begin
            state <= state_nx;
            if (ld_t0) begin
                t0_r   <= P;
                mode_r <= mode;
            end
            if (ld_sd) begin
                s_r <= sum_w;
                d_r <= diff_w;
            end
            ov_r <= ov_nx;
            z0_r <= z0_nx;
            z1_r <= z1_nx;
        end
    end

    assign busy = (state != IDLE);

`ifdef POSTADDER_OUTREG_EN
    logic             ov_q;
    redundant_poly_L3 z0_q, z1_q;

    // Optional retiming stage; stage one already holds, so copy every cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ov_q <= 1'b0;
            z0_q <= '0;
            z1_q <= '0;
        end else begin
            ov_q <= ov_r;
            z0_q <= z0_r;
            z1_q <= z1_r;
        end
    end

    assign out_valid = ov_q;
    assign Z0        = z0_q;
    assign Z1        = z1_q;
`else
    assign out_valid = ov_r;
    assign Z0        = z0_r;
    assign Z1        = z1_r;
`endif

endmodule

// File: tb/tb_postadder.sv
// Self-checking bench for postadder: reset checks, a table of frames run
// back-to-back, directed gap / mid-frame-reset sequences, and random frames.
// Expected results are queued with their due cycle and compared when
// out_valid appears.
module tb_postadder;
    import PARAMS_BN254_d0::*;

    localparam int PW = $bits(redundant_poly_L3);
    localparam int EW = 2 * PW + 32;
`ifdef POSTADDER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic [1:0]       mode;
    redundant_poly_L3 p;
    logic             out_valid;
    redundant_poly_L3 z0, z1;
    logic             busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [EW-1:0] exp_q[$];

    postadder dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .mode     (mode),
        .P        (p),
        .out_valid(out_valid),
        .Z0       (z0),
        .Z1       (z1),
        .busy     (busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic redundant_poly_L3 mk(input logic [LIMB_W-1:0] v);
        redundant_poly_L3 r;
        r    = '0;
        r[0] = v;
        return r;
    endfunction

    function automatic redundant_poly_L3 rand_poly();
        redundant_poly_L3 r;
        logic [63:0] w;
        for (int i = 0; i < NLIMB; i++) begin
            w    = {$urandom, $urandom};
            r[i] = w[LIMB_W-1:0];
        end
        return r;
    endfunction

    // Limb-wise reference arithmetic (each limb wraps on its own).
    function automatic redundant_poly_L3 padd(input redundant_poly_L3 a, input redundant_poly_L3 b, input bit sub);
        redundant_poly_L3 r;
        for (int i = 0; i < NLIMB; i++) r[i] = sub ? (a[i] - b[i]) : (a[i] + b[i]);
        return r;
    endfunction

    // Driver: present one element; it is accepted on the next posedge.
    task automatic elem(input logic [1:0] m, input redundant_poly_L3 v);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        mode     = m;
        p        = v;
    endtask

    task automatic idle(input int n, input logic [1:0] m);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            mode     = m;
            p        = rand_poly();
        end
    endtask

    // Call right after the last element of a frame is presented.
    task automatic push(input redundant_poly_L3 e0, input redundant_poly_L3 e1);
        exp_q.push_back({e0, e1, 32'(cyc + LAT)});
    endtask

    // Scoreboard monitor on the falling edge.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("z0", z0, e[EW-1 -: PW]);
                check("z1", z1, e[PW+31 -: PW]);
                check("latency_cycle", cyc, e[31:0]);
            end
        end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][31:0])) begin
            check("out_valid_missing", out_valid, 1'b1);
            e = exp_q.pop_front();
        end
    end

    typedef struct {
        logic [1:0]        m;
        int                n;
        logic [LIMB_W-1:0] e0, e1, e2;
        logic [LIMB_W-1:0] x0, x1;
    } vec_t;

    vec_t tbl[8];

    initial begin
        redundant_poly_L3 a, b, c;
        logic [1:0] m;
        int n;

        tbl[0] = '{m: 2'b00, n: 1, e0: 36'd7,  e1: 36'd0,  e2: 36'd0,   x0: 36'd7,              x1: 36'd0};
        tbl[1] = '{m: 2'b01, n: 3, e0: 36'd5,  e1: 36'd3,  e2: 36'd20,  x0: 36'd2,              x1: 36'd12};
        tbl[2] = '{m: 2'b00, n: 1, e0: 36'd1,  e1: 36'd0,  e2: 36'd0,   x0: 36'd1,              x1: 36'd0};
        tbl[3] = '{m: 2'b10, n: 2, e0: 36'd9,  e1: 36'd4,  e2: 36'd0,   x0: 36'd5,              x1: 36'd13};
        tbl[4] = '{m: 2'b11, n: 1, e0: 36'd42, e1: 36'd0,  e2: 36'd0,   x0: 36'd42,             x1: 36'd0};
        tbl[5] = '{m: 2'b01, n: 3, e0: 36'd1,  e1: 36'd1,  e2: 36'd4,   x0: 36'd0,              x1: 36'd2};
        tbl[6] = '{m: 2'b10, n: 2, e0: 36'd3,  e1: 36'd5,  e2: 36'd0,   x0: 36'hF_FFFF_FFFE,    x1: 36'd8};
        tbl[7] = '{m: 2'b01, n: 3, e0: 36'd10, e1: 36'd20, e2: 36'd100, x0: 36'hF_FFFF_FFF6,    x1: 36'd70};

        // Reset with in_valid held high: nothing may come out.
        rstn     = 1'b0;
        in_valid = 1'b1;
        mode     = 2'b00;
        p        = mk(36'd7);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_z0", z0, '0);
            check("rst_z1", z1, '0);
        end
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        in_valid = 1'b0;
        idle(2, 2'b00);

        // Table frames back-to-back; later elements carry junk mode values.
        for (int i = 0; i < 8; i++) begin
            elem(tbl[i].m, mk(tbl[i].e0));
            if (tbl[i].n >= 2) elem(2'($urandom_range(0, 3)), mk(tbl[i].e1));
            if (tbl[i].n >= 3) elem(2'($urandom_range(0, 3)), mk(tbl[i].e2));
            push(mk(tbl[i].x0), mk(tbl[i].x1));
        end
        idle(4, 2'b00);

        // Sum/diff with a 3-cycle gap while mode=00 is presented.
        elem(2'b10, mk(36'd9));
        @(negedge clk);
        idle(1, 2'b00);
        @(negedge clk);
        check("gap_busy", busy, 1'b1);
        idle(2, 2'b00);
        @(negedge clk);
        check("gap_busy_late", busy, 1'b1);
        elem(2'b00, mk(36'd4));
        push(mk(36'd5), mk(36'd13));
        idle(1, 2'b00);
        @(negedge clk);
        check("gap_busy_done", busy, 1'b0);
        idle(4, 2'b00);

        // Reset in the middle of an Fp2 frame, then a fresh frame.
        elem(2'b01, mk(36'd5));
        elem(2'b01, mk(36'd3));
        @(posedge clk);
        #1;
        rstn     = 1'b0;
        in_valid = 1'b1;
        mode     = 2'b01;
        p        = mk(36'd20);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        elem(2'b01, mk(36'd1));
        elem(2'b10, mk(36'd1));
        elem(2'b00, mk(36'd4));
        push(mk(36'd0), mk(36'd2));
        idle(4, 2'b00);

        // Random frames with random limbs and random gaps.
        for (int f = 0; f < 40; f++) begin
            m = 2'($urandom_range(0, 3));
            n = (m == MODE_FP2) ? 3 : (m == MODE_SUMDIFF) ? 2 : 1;
            a = rand_poly();
            b = rand_poly();
            c = rand_poly();
            elem(m, a);
            if (n >= 2) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 2'($urandom_range(0, 3)));
                elem(2'($urandom_range(0, 3)), b);
            end
            if (n >= 3) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 2'($urandom_range(0, 3)));
                elem(2'($urandom_range(0, 3)), c);
            end
            if (n == 1)      push(a, '0);
            else if (n == 2) push(padd(a, b, 1'b1), padd(a, b, 1'b0));
            else             push(padd(a, b, 1'b1), padd(c, padd(a, b, 1'b0), 1'b1));
            if ($urandom_range(0, 2) == 0) idle(1, 2'($urandom_range(0, 3)));
        end

        // Drain with a bounded wait.
        idle(1, 2'b00);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
